// File: rtl/cnn_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer_if
//
// Purpose : Bundles the control/handshake signals between the layer
//           sequencer and the CNN engines plus the host-side run/abort
//           controls and status flags.
//
// Signals :
//   run          host -> seq   pulse that starts a full pass
//   abort        host -> seq   synchronous cancel of the current pass
//   stage_start  seq  -> eng   one-hot start pulse, one bit per engine
//   stage_done   eng  -> seq   done from each engine (pulse or held level)
//   buf_sel      seq  -> eng   ping-pong select: read bank buf_sel,
//                              write bank ~buf_sel
//   cur_stage    seq  -> host  index of the active stage
//   busy         seq  -> host  pass in progress
//   done         seq  -> host  one-cycle pulse at the end of a pass
//   error        seq  -> host  sticky watchdog fault flag
//   err_stage    seq  -> host  index of the stage that timed out
//
// Modports: master = sequencer side, slave = host/engine side.
// ---------------------------------------------------------------------------
interface cnn_layer_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  run;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  buf_sel;
  logic [SW-1:0]         cur_stage;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [SW-1:0]         err_stage;

  modport master (
    input  run,
    input  abort,
    input  stage_done,
    output stage_start,
    output buf_sel,
    output cur_stage,
    output busy,
    output done,
    output error,
    output err_stage
  );

  modport slave (
    output run,
    output abort,
    output stage_done,
    input  stage_start,
    input  buf_sel,
    input  cur_stage,
    input  busy,
    input  done,
    input  error,
    input  err_stage
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer
//
// Purpose : Runs NUM_STAGES CNN layer engines in a fixed order. Each engine
//           gets a one-cycle start pulse and the sequencer waits for a rising
//           edge on its done line before moving on. The ping-pong feature-map
//           bank select flips after every stage so each stage reads what the
//           previous one wrote. A per-stage watchdog turns a hung engine into
//           a sticky error instead of a stalled pipeline.
//
// Parameters:
//   NUM_STAGES      number of engines sequenced (1..16)
//   TIMEOUT_CYCLES  max cycles in WAIT for one stage (1..2^20-1)
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    cnn_layer_sequencer_if.master (run/abort in, stage handshake,
//          buffer select and status out)
// ---------------------------------------------------------------------------
module cnn_layer_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   reset,
  cnn_layer_sequencer_if.master bus
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  // Wide enough for the largest legal TIMEOUT_CYCLES.
  localparam int TW = 20;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STG = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [SW-1:0]         r_cur_stage;
  logic                  r_buf_sel;
  logic                  r_error;
  logic [SW-1:0]         r_err_stage;
  logic [TW-1:0]         r_timer;
  logic [NUM_STAGES-1:0] r_done_q;

  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_last;
  logic [NUM_STAGES-1:0] w_stage_start;
  logic                  w_busy;
  logic                  w_done;

  // Only a fresh rising edge on the active engine's done line counts, so a
  // level left high from an earlier pass cannot complete a stage.
  assign w_complete = bus.stage_done[r_cur_stage] & ~r_done_q[r_cur_stage];
  assign w_timeout  = (r_timer == TMAX);
  assign w_last     = (r_cur_stage == LAST_STG);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic; abort overrides every transition out of a busy state
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if ((r_state != S_IDLE) && bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run && !bus.abort) begin
            w_next = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          w_next = S_WAIT;
        end
        S_WAIT: begin
          // Completion wins over a timeout landing on the same cycle.
          if (w_complete) begin
            w_next = S_ADVANCE;
          end else if (w_timeout) begin
            w_next = S_FAULT;
          end
        end
        S_ADVANCE: begin
          w_next = w_last ? S_FINISH : S_LAUNCH;
        end
        S_FINISH: begin
          w_next = S_IDLE;
        end
        S_FAULT: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs decoded from the state; start pulse is one-hot on cur_stage
  // ---------------------------------------------------------------------
  always_comb begin
    w_stage_start = '0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_LAUNCH: begin
        w_stage_start[r_cur_stage] = 1'b1;
        w_busy                     = 1'b1;
      end
      S_WAIT: begin
        w_busy = 1'b1;
      end
      S_ADVANCE: begin
        w_busy = 1'b1;
      end
      S_FINISH: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage index, bank select, watchdog timer and fault capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_stage <= '0;
      r_buf_sel   <= 1'b0;
      r_error     <= 1'b0;
      r_err_stage <= '0;
      r_timer     <= '0;
      r_done_q    <= '0;
    end else begin
      // Edge-detect history is kept in every state so stale levels are seen.
      r_done_q <= bus.stage_done;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_LAUNCH) begin
            r_cur_stage <= '0;
            r_buf_sel   <= 1'b0;
            r_error     <= 1'b0;
            r_err_stage <= '0;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          if (w_next == S_WAIT) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ADVANCE: begin
          if (w_next != S_IDLE) begin
            r_buf_sel <= ~r_buf_sel;
            if (!w_last) begin
              r_cur_stage <= r_cur_stage + SW'(1);
            end
          end
        end
        S_FAULT: begin
          if (!bus.abort) begin
            r_error     <= 1'b1;
            r_err_stage <= r_cur_stage;
          end
        end
        default: begin
          r_timer <= r_timer;
        end
      endcase
    end
  end

  assign bus.stage_start = w_stage_start;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.buf_sel     = r_buf_sel;
  assign bus.cur_stage   = r_cur_stage;
  assign bus.error       = r_error;
  assign bus.err_stage   = r_err_stage;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_sequencer
//
// Scoreboard bench for cnn_layer_sequencer (NUM_STAGES=3, TIMEOUT_CYCLES=16).
// Stimulus pushes the expected observable events (start pulses, done pulse,
// busy fall, error rise/clear) with their cycle stamps; a monitor samples the
// DUT on every falling clock edge and pops/compares each event it sees.
// Inputs are driven right after a falling edge and sampled on the next
// rising edge; cyc counts rising edges.
// ---------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

  localparam int NS = 3;
  localparam int TO = 16;

  localparam int EV_START   = 0;
  localparam int EV_DONE    = 1;
  localparam int EV_BUSYLOW = 2;
  localparam int EV_ERR     = 3;
  localparam int EV_ERRCLR  = 4;

  typedef struct {
    int kind;
    int stage;
    int bsel;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  ev_t  exp_q[$];

  cnn_layer_sequencer_if #(.NUM_STAGES(NS)) bus ();

  cnn_layer_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_START:   return "START";
      EV_DONE:    return "DONE";
      EV_BUSYLOW: return "BUSYLOW";
      EV_ERR:     return "ERR";
      EV_ERRCLR:  return "ERRCLR";
      default:    return "?";
    endcase
  endfunction

  // Index of the single set bit, -2 if the vector is not one-hot.
  function automatic int oh_idx(input logic [NS-1:0] v);
    int idx;
    idx = -2;
    if ($countones(v) == 1) begin
      for (int i = 0; i < NS; i++) if (v[i]) idx = i;
    end
    return idx;
  endfunction

  task automatic expect_ev(input int kind, input int stage, input int bsel, input int c);
    ev_t e;
    e.kind = kind; e.stage = stage; e.bsel = bsel; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int stage, input int bsel);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event_unexpected: got %s stage=%0d bsel=%0d cyc=%0d, required no event",
               kname(kind), stage, bsel, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.stage != stage || e.bsel != bsel || e.cyc != cyc) begin
        fails++;
        $display("FAIL event_%s: got %s stage=%0d bsel=%0d cyc=%0d, required %s stage=%0d bsel=%0d cyc=%0d",
                 kname(e.kind), kname(kind), stage, bsel, cyc,
                 kname(e.kind), e.stage, e.bsel, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  initial begin : monitor
    logic pb;
    logic pe;
    pb = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.stage_start != '0) observe(EV_START, oh_idx(bus.stage_start), int'(bus.buf_sel));
      if (bus.done)              observe(EV_DONE, int'(bus.cur_stage), int'(bus.buf_sel));
      if (pb && !bus.busy)       observe(EV_BUSYLOW, int'(bus.cur_stage), int'(bus.buf_sel));
      if (!pe && bus.error)      observe(EV_ERR, int'(bus.err_stage), int'(bus.buf_sel));
      if (pe && !bus.error)      observe(EV_ERRCLR, int'(bus.cur_stage), int'(bus.buf_sel));
      pb = bus.busy;
      pe = bus.error;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
  endtask

  task automatic pulse_done(input int i);
    bus.stage_done[i] = 1'b1;
    @(negedge clk);
    bus.stage_done[i] = 1'b0;
  endtask

  // Full pass with engines answering 5/10/3 cycles after their start pulse.
  task automatic pass3(input bit noise);
    int r;
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_START,   1, 1, r + 8);
    expect_ev(EV_START,   2, 0, r + 20);
    expect_ev(EV_DONE,    2, 1, r + 25);
    expect_ev(EV_BUSYLOW, 2, 1, r + 26);
    pulse_run();
    at_cyc(r + 6);  pulse_done(0);
    if (noise) begin
      at_cyc(r + 10); pulse_run();
      at_cyc(r + 12); pulse_run();
    end
    at_cyc(r + 18); pulse_done(1);
    at_cyc(r + 23); pulse_done(2);
    at_cyc(r + 30);
  endtask

  initial begin : stimulus
    int r;
    bus.run        = 1'b0;
    bus.abort      = 1'b0;
    bus.stage_done = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_stage_start", int'(bus.stage_start), 0);
    chk("rst_buf_sel",     int'(bus.buf_sel),     0);
    chk("rst_cur_stage",   int'(bus.cur_stage),   0);
    chk("rst_busy",        int'(bus.busy),        0);
    chk("rst_done",        int'(bus.done),        0);
    chk("rst_error",       int'(bus.error),       0);
    chk("rst_err_stage",   int'(bus.err_stage),   0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Normal pass, then a pass with stray run pulses during stage 1.
    pass3(1'b0);
    pass3(1'b1);

    // run together with abort in IDLE must not start a pass.
    bus.run = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.run = 1'b0; bus.abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_abort_blocks_run_busy", int'(bus.busy), 0);

    // Stage 1 never answers: fault after 16 WAIT cycles.
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_START,   1, 1, r + 8);
    expect_ev(EV_BUSYLOW, 1, 1, r + 25);
    expect_ev(EV_ERR,     1, 1, r + 26);
    pulse_run();
    at_cyc(r + 6); pulse_done(0);
    at_cyc(r + 32);
    chk("fault_busy",      int'(bus.busy),  0);
    chk("fault_error_set", int'(bus.error), 1);

    // Engine 0 holds done high from before; next run clears error and must
    // wait for a fresh edge. A stray done on stage 2 is ignored meanwhile.
    bus.stage_done[0] = 1'b1;
    repeat (2) @(negedge clk);
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_ERRCLR,  0, 0, r + 1);
    expect_ev(EV_START,   1, 1, r + 8);
    expect_ev(EV_START,   2, 0, r + 20);
    expect_ev(EV_DONE,    2, 1, r + 25);
    expect_ev(EV_BUSYLOW, 2, 1, r + 26);
    pulse_run();
    at_cyc(r + 3); pulse_done(2);
    at_cyc(r + 4); bus.stage_done[0] = 1'b0;
    at_cyc(r + 6); bus.stage_done[0] = 1'b1;
    at_cyc(r + 18); pulse_done(1);
    at_cyc(r + 23); pulse_done(2);
    at_cyc(r + 30);
    bus.stage_done[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Abort during stage 1 WAIT, then a clean pass from stage 0.
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_START,   1, 1, r + 8);
    expect_ev(EV_BUSYLOW, 1, 1, r + 12);
    pulse_run();
    at_cyc(r + 6); pulse_done(0);
    at_cyc(r + 11);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    at_cyc(r + 16);
    chk("abort_busy",  int'(bus.busy),  0);
    chk("abort_error", int'(bus.error), 0);
    pass3(1'b0);

    // Stage 1 done edge lands on the final timeout cycle: completion wins.
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_START,   1, 1, r + 8);
    expect_ev(EV_START,   2, 0, r + 26);
    expect_ev(EV_DONE,    2, 1, r + 31);
    expect_ev(EV_BUSYLOW, 2, 1, r + 32);
    pulse_run();
    at_cyc(r + 6);  pulse_done(0);
    at_cyc(r + 24); pulse_done(1);
    at_cyc(r + 29); pulse_done(2);
    at_cyc(r + 36);
    chk("coincide_error", int'(bus.error), 0);

    // Asynchronous reset in the middle of LAUNCH.
    r = cyc;
    expect_ev(EV_START,   0, 0, r + 1);
    expect_ev(EV_BUSYLOW, 0, 0, r + 2);
    pulse_run();
    #2 reset = 1'b0;
    #1;
    chk("arst_stage_start", int'(bus.stage_start), 0);
    chk("arst_busy",        int'(bus.busy),        0);
    chk("arst_done",        int'(bus.done),        0);
    chk("arst_buf_sel",     int'(bus.buf_sel),     0);
    chk("arst_cur_stage",   int'(bus.cur_stage),   0);
    chk("arst_error",       int'(bus.error),       0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
